multicycle_control: RTL and testbench

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

---
 rtl/multicycle_control.sv | 157 +++++++++++++++
 tb/tb_multicycle_control.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control.sv
// multicycle_control: FSM controller for a multicycle MIPS-style datapath.
// Decodes opcode/funct into per-state datapath strobes with a memory-ready handshake.
module multicycle_control (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       iord,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       pc_en,
    output logic       reg_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       alu_src_a,
    output logic       illegal,
    output logic [1:0] alu_src_b,
    output logic [1:0] pc_src,
    output logic [2:0] alu_op,
    output logic [3:0] state
);
    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        EXEC   = 4'd6,
        ALUWB  = 4'd7,
        BRANCH = 4'd8,
        ADDIEX = 4'd9,
        ADDIWB = 4'd10,
        JUMP   = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    state_t cur, nxt;
    logic mem_read_raw, mem_write_raw, ir_write_raw, pc_en_raw, reg_write_raw, illegal_raw;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) cur <= FETCH;
        else          cur <= nxt;
    end

    always_comb begin
        nxt           = FETCH;
        iord          = 1'b0;
        mem_read_raw  = 1'b0;
        mem_write_raw = 1'b0;
        ir_write_raw  = 1'b0;
        pc_en_raw     = 1'b0;
        reg_write_raw = 1'b0;
        reg_dst       = 1'b0;
        mem_to_reg    = 1'b0;
        alu_src_a     = 1'b0;
        illegal_raw   = 1'b0;
        alu_src_b     = 2'b00;
        pc_src        = 2'b00;
        alu_op        = 3'b010;
        case (cur)
            FETCH: begin
                mem_read_raw = 1'b1;
                alu_src_b    = 2'b01;
                ir_write_raw = mem_ready;
                pc_en_raw    = mem_ready;
                nxt          = mem_ready ? DECODE : FETCH;
            end
            DECODE: begin
                alu_src_b = 2'b11;
                case (opcode)
                    OP_LW, OP_SW:   nxt = MEMADR;
                    OP_RTYPE:       nxt = EXEC;
                    OP_BEQ, OP_BNE: nxt = BRANCH;
                    OP_ADDI:        nxt = ADDIEX;
                    OP_J:           nxt = JUMP;
                    default:        illegal_raw = 1'b1;
                endcase
            end
            MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                nxt       = (opcode == OP_SW) ? MEMWR : MEMRD;
            end
            MEMRD: begin
                iord         = 1'b1;
                mem_read_raw = 1'b1;
                nxt          = mem_ready ? MEMWB : MEMRD;
            end
            MEMWB: begin
                reg_write_raw = 1'b1;
                mem_to_reg    = 1'b1;
            end
            MEMWR: begin
                iord          = 1'b1;
                mem_write_raw = 1'b1;
                nxt           = mem_ready ? FETCH : MEMWR;
            end
            EXEC: begin
                alu_src_a = 1'b1;
                nxt       = ALUWB;
                case (funct)
                    6'b100000: alu_op = 3'b010;
                    6'b100010: alu_op = 3'b110;
                    6'b100100: alu_op = 3'b000;
                    6'b100101: alu_op = 3'b001;
                    6'b101010: alu_op = 3'b111;
                    default: begin
                        illegal_raw = 1'b1;
                        nxt         = FETCH;
                    end
                endcase
            end
            ALUWB: begin
                reg_write_raw = 1'b1;
                reg_dst       = 1'b1;
            end
            BRANCH: begin
                alu_src_a = 1'b1;
                alu_op    = 3'b110;
                pc_src    = 2'b01;
                // opcode[0] separates bne from beq
                pc_en_raw = opcode[0] ? ~zero : zero;
            end
            ADDIEX: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                nxt       = ADDIWB;
            end
            ADDIWB: reg_write_raw = 1'b1;
            JUMP: begin
                pc_src    = 2'b10;
                pc_en_raw = 1'b1;
            end
            default: nxt = FETCH;
        endcase
    end

    // Strobes are forced low while reset is held so nothing fires during reset
    assign mem_read  = mem_read_raw  & reset_n;
    assign mem_write = mem_write_raw & reset_n;
    assign ir_write  = ir_write_raw  & reset_n;
    assign pc_en     = pc_en_raw     & reset_n;
    assign reg_write = reg_write_raw & reset_n;
    assign illegal   = illegal_raw   & reset_n;
    assign state     = cur;
endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: table-driven per-cycle check of state and all outputs,
// plus hand-written reset-during-wait sequences.
module tb_multicycle_control;
    logic       clk = 1'b0;
    logic       reset_n;
    logic [5:0] opcode, funct;
    logic       zero, mem_ready;
    logic       iord, mem_read, mem_write, ir_write, pc_en, reg_write;
    logic       reg_dst, mem_to_reg, alu_src_a, illegal;
    logic [1:0] alu_src_b, pc_src;
    logic [2:0] alu_op;
    logic [3:0] state;
    logic [16:0] act;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [5:0]  op;
        logic [5:0]  fn;
        logic        z;
        logic        rdy;
        logic [3:0]  st;
        logic [16:0] o;
    } vec_t;

    vec_t vecs[$];

    multicycle_control dut (
        .clk(clk), .reset_n(reset_n), .opcode(opcode), .funct(funct), .zero(zero),
        .mem_ready(mem_ready), .iord(iord), .mem_read(mem_read), .mem_write(mem_write),
        .ir_write(ir_write), .pc_en(pc_en), .reg_write(reg_write), .reg_dst(reg_dst),
        .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a), .illegal(illegal),
        .alu_src_b(alu_src_b), .pc_src(pc_src), .alu_op(alu_op), .state(state)
    );

    always #5 clk = ~clk;

    assign act = {iord, mem_read, mem_write, ir_write, pc_en, reg_write, reg_dst,
                  mem_to_reg, alu_src_a, illegal, alu_src_b, pc_src, alu_op};

    function automatic logic [16:0] ex(input logic io, mr, mw, irw, pce, rw, rd, m2r, asa, ill,
                                       input logic [1:0] asb, pcs, input logic [2:0] aop);
        return {io, mr, mw, irw, pce, rw, rd, m2r, asa, ill, asb, pcs, aop};
    endfunction

    function automatic logic [16:0] fo(input logic r);
        return ex(0, 1, 0, r, r, 0, 0, 0, 0, 0, 2'b01, 2'b00, 3'b010);
    endfunction

    function automatic logic [16:0] dc(input logic ill);
        return ex(0, 0, 0, 0, 0, 0, 0, 0, 0, ill, 2'b11, 2'b00, 3'b010);
    endfunction

    task automatic add(input logic [5:0] op, fn, input logic z, rdy, input logic [3:0] st,
                       input logic [16:0] o);
        vec_t v;
        v.op = op; v.fn = fn; v.z = z; v.rdy = rdy; v.st = st; v.o = o;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [16:0] got, input logic [16:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%h want=%h (t=%0t)", name, got, want, $time);
        end
    endtask

    task automatic apply(input vec_t v, input int idx);
        @(negedge clk);
        opcode = v.op; funct = v.fn; zero = v.z; mem_ready = v.rdy;
        #1;
        chk($sformatf("row%0d state", idx), {13'd0, state}, {13'd0, v.st});
        chk($sformatf("row%0d outputs", idx), act, v.o);
    endtask

    task automatic rtype(input logic [5:0] fn, input logic [2:0] aop);
        add(6'h00, fn, 0, 1, 4'd0, fo(1));
        add(6'h00, fn, 0, 1, 4'd1, dc(0));
        add(6'h00, fn, 0, 1, 4'd6, ex(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00, aop));
        add(6'h00, fn, 0, 1, 4'd7, ex(0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 2'b00, 2'b00, 3'b010));
    endtask

    task automatic branch(input logic [5:0] op, input logic z, input logic taken);
        add(op, 6'h00, z, 1, 4'd0, fo(1));
        add(op, 6'h00, z, 1, 4'd1, dc(0));
        add(op, 6'h00, z, 1, 4'd8, ex(0, 0, 0, 0, taken, 0, 0, 0, 1, 0, 2'b00, 2'b01, 3'b110));
    endtask

    initial begin
        reset_n = 1'b0; opcode = 6'h00; funct = 6'h00; zero = 1'b0; mem_ready = 1'b0;
        #1;
        chk("reset state", {13'd0, state}, 17'd0);
        chk("reset outputs", act, ex(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b01, 2'b00, 3'b010));
        @(negedge clk);
        reset_n = 1'b1;

        rtype(6'b100000, 3'b010);
        rtype(6'b100010, 3'b110);
        rtype(6'b100100, 3'b000);
        rtype(6'b100101, 3'b001);
        rtype(6'b101010, 3'b111);
        // unknown funct: illegal in EXEC, no write-back
        add(6'h00, 6'h00, 0, 1, 4'd0, fo(1));
        add(6'h00, 6'h00, 0, 1, 4'd1, dc(0));
        add(6'h00, 6'h00, 0, 1, 4'd6, ex(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 2'b00, 2'b00, 3'b010));
        // fetch stall then lw with two MEMRD wait cycles
        add(6'h23, 6'h00, 0, 0, 4'd0, fo(0));
        add(6'h23, 6'h00, 0, 0, 4'd0, fo(0));
        add(6'h23, 6'h00, 0, 1, 4'd0, fo(1));
        add(6'h23, 6'h00, 0, 1, 4'd1, dc(0));
        add(6'h23, 6'h00, 0, 0, 4'd2, ex(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 2'b10, 2'b00, 3'b010));
        add(6'h23, 6'h00, 0, 0, 4'd3, ex(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 3'b010));
        add(6'h23, 6'h00, 0, 0, 4'd3, ex(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 3'b010));
        add(6'h23, 6'h00, 0, 1, 4'd3, ex(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 3'b010));
        add(6'h23, 6'h00, 0, 1, 4'd4, ex(0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 2'b00, 2'b00, 3'b010));
        // sw with one MEMWR wait cycle
        add(6'h2b, 6'h00, 0, 1, 4'd0, fo(1));
        add(6'h2b, 6'h00, 0, 1, 4'd1, dc(0));
        add(6'h2b, 6'h00, 0, 0, 4'd2, ex(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 2'b10, 2'b00, 3'b010));
        add(6'h2b, 6'h00, 0, 0, 4'd5, ex(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 3'b010));
        add(6'h2b, 6'h00, 0, 1, 4'd5, ex(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 3'b010));
        branch(6'h04, 1, 1);
        branch(6'h05, 1, 0);
        branch(6'h04, 0, 0);
        branch(6'h05, 0, 1);
        // addi
        add(6'h08, 6'h00, 0, 1, 4'd0, fo(1));
        add(6'h08, 6'h00, 0, 1, 4'd1, dc(0));
        add(6'h08, 6'h00, 0, 1, 4'd9, ex(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 2'b10, 2'b00, 3'b010));
        add(6'h08, 6'h00, 0, 1, 4'd10, ex(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 2'b00, 2'b00, 3'b010));
        // j
        add(6'h02, 6'h00, 0, 1, 4'd0, fo(1));
        add(6'h02, 6'h00, 0, 1, 4'd1, dc(0));
        add(6'h02, 6'h00, 0, 1, 4'd11, ex(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 2'b00, 2'b10, 3'b010));
        // illegal opcode
        add(6'h3f, 6'h00, 0, 1, 4'd0, fo(1));
        add(6'h3f, 6'h00, 0, 1, 4'd1, dc(1));
        add(6'h3f, 6'h00, 0, 0, 4'd0, fo(0));

        foreach (vecs[i]) apply(vecs[i], i);

        // sw interrupted by reset while waiting in MEMWR
        vecs.delete();
        add(6'h2b, 6'h00, 0, 1, 4'd0, fo(1));
        add(6'h2b, 6'h00, 0, 1, 4'd1, dc(0));
        add(6'h2b, 6'h00, 0, 0, 4'd2, ex(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 2'b10, 2'b00, 3'b010));
        add(6'h2b, 6'h00, 0, 0, 4'd5, ex(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 3'b010));
        foreach (vecs[i]) apply(vecs[i], 100 + i);
        #2;
        reset_n = 1'b0;
        #1;
        chk("mid-wait reset state", {13'd0, state}, 17'd0);
        chk("mid-wait reset outputs", act, ex(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b01, 2'b00, 3'b010));
        mem_ready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            #1;
            chk($sformatf("held reset state %0d", k), {13'd0, state}, 17'd0);
            chk($sformatf("held reset strobes %0d", k),
                {11'd0, mem_read, mem_write, ir_write, pc_en, reg_write, illegal}, 17'd0);
        end
        mem_ready = 1'b0;
        reset_n = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            #1;
            chk($sformatf("post reset state %0d", k), {13'd0, state}, 17'd0);
            chk($sformatf("post reset outputs %0d", k), act, fo(0));
        end

        // lw interrupted by reset while waiting in MEMRD
        vecs.delete();
        add(6'h23, 6'h00, 0, 1, 4'd0, fo(1));
        add(6'h23, 6'h00, 0, 1, 4'd1, dc(0));
        add(6'h23, 6'h00, 0, 0, 4'd2, ex(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 2'b10, 2'b00, 3'b010));
        add(6'h23, 6'h00, 0, 0, 4'd3, ex(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 3'b010));
        foreach (vecs[i]) apply(vecs[i], 200 + i);
        #2;
        reset_n = 1'b0;
        #1;
        chk("memrd reset state", {13'd0, state}, 17'd0);
        chk("memrd reset outputs", act, ex(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b01, 2'b00, 3'b010));
        @(negedge clk);
        reset_n = 1'b1;
        mem_ready = 1'b1;
        #1;
        chk("release fetch outputs", act, fo(1));
        @(negedge clk);
        #1;
        chk("release first edge state", {13'd0, state}, 17'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
